// File: rtl/fsm_spi_sequencer.sv
// fsm_spi_sequencer
//   Buffers bytes from the SPI slave and steps the state-sequence FSM one bit
//   per clock-enable pulse. After each step it captures the FSM state and
//   offers an ASCII report byte ('0'..'3') to the transmitter over valid/ready.
//   It also drives the FSM's active-low reset so the FSM can be resynchronised.
//
// Ports
//   i_Clk, i_Rst          system clock, synchronous active-high reset
//   i_RX_DV, i_RX_Byte    one-cycle byte strobe from the SPI slave
//   i_Clear               request: resync FSM, flush FIFO, clear overflow
//   i_Fsm_State           current FSM state (0..3)
//   o_Fsm_Signal          bit presented to the FSM
//   o_Fsm_En              FSM clock-enable, one transition per high cycle
//   o_Fsm_Rst_n           active-low FSM reset
//   o_TX_DV, o_TX_Byte    report byte and its valid
//   i_TX_Ready            transmitter ready
//   o_Overflow            sticky: a byte was dropped on a full FIFO
//   o_Busy                state not idle or FIFO non-empty
//
// state    | meaning
// S_IDLE   | wait for clear request or queued byte
// S_LOAD   | pop FIFO head into the shift register
// S_STEP   | pulse o_Fsm_En with the current bit
// S_SETTLE | capture the FSM state into the report register
// S_REPORT | offer report byte until accepted
// S_CLEAR  | hold FSM in reset, flush FIFO, clear overflow
module fsm_spi_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Clear,
  input  logic [7:0] i_Fsm_State,
  output logic       o_Fsm_Signal,
  output logic       o_Fsm_En,
  output logic       o_Fsm_Rst_n,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Ready,
  output logic       o_Overflow,
  output logic       o_Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, drop;
  logic          pending, clear_req;
  logic [7:0]    head, shreg, report;
  logic [2:0]    bit_cnt;
  logic          fsm_signal, overflow;
  logic          unused_state_bits;

  // Only the low nibble of the FSM state feeds the report.
  assign unused_state_bits = ^i_Fsm_State[7:4];

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign pop   = (state == S_LOAD);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push  = i_RX_DV && (state != S_CLEAR) && (!full || pop);
  assign drop  = i_RX_DV && (state != S_CLEAR) && full && !pop;
  assign clear_req = pending | i_Clear;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clear_req)   state_nxt = S_CLEAR;
        else if (!empty) state_nxt = S_LOAD;
      end
      S_LOAD:   state_nxt = S_STEP;
      S_STEP:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_REPORT;
      S_REPORT: begin
        if (i_TX_Ready) state_nxt = (bit_cnt == 3'd7) ? S_IDLE : S_STEP;
      end
      S_CLEAR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // In S_IDLE a clear is served directly, so only requests seen elsewhere wait.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)                                pending <= 1'b0;
    else if (state == S_CLEAR)                pending <= 1'b0;
    else if (i_Clear && (state != S_IDLE))    pending <= 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (push && !i_Rst) mem[wr_ptr] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || (state == S_CLEAR)) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      fsm_signal <= 1'b0;
      report     <= 8'h00;
    end else begin
      case (state)
        S_LOAD: begin
          shreg      <= head;
          bit_cnt    <= 3'd0;
          fsm_signal <= MSB_FIRST ? head[7] : head[0];
        end
        S_SETTLE: report <= 8'h30 + {4'h0, i_Fsm_State[3:0]};
        S_REPORT: begin
          if (i_TX_Ready && (bit_cnt != 3'd7)) begin
            shreg      <= MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
            bit_cnt    <= bit_cnt + 3'd1;
            fsm_signal <= MSB_FIRST ? shreg[6] : shreg[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Fsm_Signal = fsm_signal;
  assign o_Fsm_En     = (state == S_STEP);
  assign o_TX_DV      = (state == S_REPORT);
  assign o_TX_Byte    = report;
  assign o_Overflow   = overflow;
  assign o_Busy       = (state != S_IDLE) || !empty;
  assign o_Fsm_Rst_n  = ~(i_Rst | (state == S_CLEAR));

endmodule
